// File: rtl/video_mode_sequencer_pkg.sv
// rtl/video_mode_sequencer_pkg.sv - control-register map, display mode timing table and sequencer types
// Purpose: definitions shared by the mode sequencer and the video unit.
// Ports: none (package).
package video_pkg;

  // Control-register word addresses (byte address = {word, 2'b00}).
  localparam logic [9:0] CR_DEPTH      = 10'h002;
  localparam logic [9:0] CR_ENABLE     = 10'h003;
  localparam logic [9:0] CR_POLARITY   = 10'h004;
  localparam logic [9:0] CR_PXLFREQ    = 10'h005;
  localparam logic [9:0] CR_FB_WIDTH   = 10'h006;
  localparam logic [9:0] CR_FB_HEIGHT  = 10'h007;
  localparam logic [9:0] CR_FB_BPL     = 10'h008;
  localparam logic [9:0] CR_H_TOTAL    = 10'h010;
  localparam logic [9:0] CR_H_END_DISP = 10'h011;
  localparam logic [9:0] CR_H_SRT_SYNC = 10'h012;
  localparam logic [9:0] CR_H_END_SYNC = 10'h013;
  localparam logic [9:0] CR_V_TOTAL    = 10'h014;
  localparam logic [9:0] CR_V_END_DISP = 10'h015;
  localparam logic [9:0] CR_V_SRT_SYNC = 10'h016;
  localparam logic [9:0] CR_V_END_SYNC = 10'h017;

  localparam logic [3:0] LAST_IDX = 4'd13;

  typedef struct packed {
    logic [7:0]  pxlfreq;
    logic [1:0]  pol;        // {v, h}
    logic [15:0] h_total;
    logic [15:0] h_end_disp;
    logic [15:0] h_srt_sync;
    logic [15:0] h_end_sync;
    logic [15:0] v_total;
    logic [15:0] v_end_disp;
    logic [15:0] v_srt_sync;
    logic [15:0] v_end_sync;
  } vmode_t;

  typedef enum logic [2:0] {
    S_IDLE, S_DISABLE, S_WRITE, S_WAIT_LOCK, S_SETTLE, S_ENABLE
  } seq_state_e;

  function automatic vmode_t mode_table(input logic [1:0] mode);
    vmode_t m;
    case (mode)
      2'd0:    m = '{8'd25, 2'b11, 16'd800,  16'd640,  16'd656,  16'd752,  16'd525, 16'd480, 16'd490, 16'd492};
      2'd1:    m = '{8'd40, 2'b00, 16'd1056, 16'd800,  16'd840,  16'd968,  16'd628, 16'd600, 16'd601, 16'd605};
      2'd2:    m = '{8'd65, 2'b11, 16'd1344, 16'd1024, 16'd1048, 16'd1184, 16'd806, 16'd768, 16'd771, 16'd777};
      default: m = '0;
    endcase
    return m;
  endfunction

  // Bytes per line rounded up to a multiple of 8; 15-bit intermediate, 14-bit result.
  function automatic logic [13:0] fb_bpl(input logic [15:0] width, input logic [1:0] depth);
    logic [14:0] w;
    logic [14:0] bytes;
    logic [14:0] rnd;
    w = width[14:0];
    case (depth)
      2'd0:    bytes = w << 2;
      2'd1:    bytes = w << 1;
      2'd2:    bytes = w;
      default: bytes = w >> 1;
    endcase
    rnd = (bytes + 15'd7) & ~15'd7;
    return rnd[13:0];
  endfunction

  // Register word written at each WRITE step.
  function automatic logic [9:0] table_word(input logic [3:0] idx);
    logic [9:0] w;
    case (idx)
      4'd0:    w = CR_DEPTH;
      4'd1:    w = CR_POLARITY;
      4'd2:    w = CR_PXLFREQ;
      4'd3:    w = CR_FB_WIDTH;
      4'd4:    w = CR_FB_HEIGHT;
      4'd5:    w = CR_FB_BPL;
      default: w = CR_H_TOTAL + {6'd0, idx - 4'd6};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/video_mode_sequencer_reg_mux.sv
// rtl/video_mode_sequencer_reg_mux.sv - host/sequencer arbitration onto the control-register port
// Purpose: host always owns the port when it drives host_en_i; sequencer uses idle cycles.
// Ports: host_* (host BRAM port in), seq_* (sequencer access in), ctl_* (register block out),
//        stall_o (sequencer must hold its access this cycle).
module vms_reg_mux (
  input  logic        host_en_i,
  input  logic [3:0]  host_we_i,
  input  logic [11:0] host_addr_i,
  input  logic [31:0] host_wrdata_i,
  input  logic        seq_en_i,
  input  logic [9:0]  seq_word_i,
  input  logic [31:0] seq_wrdata_i,
  output logic        ctl_en_o,
  output logic [3:0]  ctl_we_o,
  output logic [11:0] ctl_addr_o,
  output logic [31:0] ctl_wrdata_o,
  output logic        stall_o
);

  assign stall_o = host_en_i;

  always_comb begin
    ctl_en_o     = 1'b0;
    ctl_we_o     = 4'h0;
    ctl_addr_o   = 12'h000;
    ctl_wrdata_o = 32'h0;
    if (host_en_i) begin
      ctl_en_o     = 1'b1;
      ctl_we_o     = host_we_i;
      ctl_addr_o   = host_addr_i;
      ctl_wrdata_o = host_wrdata_i;
    end else if (seq_en_i) begin
      ctl_en_o     = 1'b1;
      ctl_we_o     = 4'hF;
      ctl_addr_o   = {seq_word_i, 2'b00};
      ctl_wrdata_o = seq_wrdata_i;
    end
  end

endmodule

// File: rtl/video_mode_sequencer.sv
// rtl/video_mode_sequencer.sv - programs a full display mode into the video control registers
// Purpose: disable display, write 14 timing words, wait for pixel-clock lock and settle, optionally enable.
// Ports: mem_clk/rst_ni; req_i, mode_i, depth_i, enable_after_i (request); clk_locked_i (async lock);
//        busy_o, done_o, err_o, conflict_o (status); host_* / host_rddata_o (host port);
//        ctl_* / ctl_rddata_i (register block port).
module video_mode_sequencer
  import video_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65535
) (
  input  logic        mem_clk,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [1:0]  mode_i,
  input  logic [1:0]  depth_i,
  input  logic        enable_after_i,
  input  logic        clk_locked_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        conflict_o,
  input  logic        host_en_i,
  input  logic [3:0]  host_we_i,
  input  logic [11:0] host_addr_i,
  input  logic [31:0] host_wrdata_i,
  output logic [31:0] host_rddata_o,
  output logic        ctl_en_o,
  output logic [3:0]  ctl_we_o,
  output logic [11:0] ctl_addr_o,
  output logic [31:0] ctl_wrdata_o,
  input  logic [31:0] ctl_rddata_i
);

  localparam logic [16:0] LOCK_LAST   = 17'(LOCK_TIMEOUT - 1);
  localparam logic [16:0] SETTLE_LAST = 17'(SETTLE_CYCLES - 1);

  seq_state_e  r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [16:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_mode, r_depth;
  logic        r_en_after;
  logic [1:0]  r_lock_sync;
  logic        r_busy, r_done, r_err, r_conflict;
  logic        w_busy_nxt, w_done_nxt, w_err_nxt, w_conflict_nxt, w_latch;
  logic        w_stall, w_seq_en, w_lock;
  logic [9:0]  w_seq_word;
  logic [31:0] w_seq_data, w_tbl_data;
  vmode_t      w_tbl;

  assign w_lock        = r_lock_sync[1];
  assign w_tbl         = mode_table(r_mode);
  assign host_rddata_o = ctl_rddata_i;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign conflict_o    = r_conflict;

  vms_reg_mux u_mux (
    .host_en_i     (host_en_i),
    .host_we_i     (host_we_i),
    .host_addr_i   (host_addr_i),
    .host_wrdata_i (host_wrdata_i),
    .seq_en_i      (w_seq_en),
    .seq_word_i    (w_seq_word),
    .seq_wrdata_i  (w_seq_data),
    .ctl_en_o      (ctl_en_o),
    .ctl_we_o      (ctl_we_o),
    .ctl_addr_o    (ctl_addr_o),
    .ctl_wrdata_o  (ctl_wrdata_o),
    .stall_o       (w_stall)
  );

  always_comb begin
    w_tbl_data = 32'h0;
    case (r_idx)
      4'd0:    w_tbl_data = {30'd0, r_depth};
      4'd1:    w_tbl_data = {30'd0, w_tbl.pol};
      4'd2:    w_tbl_data = {24'd0, w_tbl.pxlfreq};
      4'd3:    w_tbl_data = {16'd0, w_tbl.h_end_disp};
      4'd4:    w_tbl_data = {16'd0, w_tbl.v_end_disp};
      4'd5:    w_tbl_data = {18'd0, fb_bpl(w_tbl.h_end_disp, r_depth)};
      4'd6:    w_tbl_data = {16'd0, w_tbl.h_total};
      4'd7:    w_tbl_data = {16'd0, w_tbl.h_end_disp};
      4'd8:    w_tbl_data = {16'd0, w_tbl.h_srt_sync};
      4'd9:    w_tbl_data = {16'd0, w_tbl.h_end_sync};
      4'd10:   w_tbl_data = {16'd0, w_tbl.v_total};
      4'd11:   w_tbl_data = {16'd0, w_tbl.v_end_disp};
      4'd12:   w_tbl_data = {16'd0, w_tbl.v_srt_sync};
      4'd13:   w_tbl_data = {16'd0, w_tbl.v_end_sync};
      default: w_tbl_data = 32'h0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_conflict_nxt = r_conflict;
    w_latch        = 1'b0;
    w_seq_en       = 1'b0;
    w_seq_word     = CR_ENABLE;
    w_seq_data     = 32'h0;

    // Host turning the display on mid-sequence would be undone by our later writes; flag it.
    if (r_busy && host_en_i && host_we_i == 4'hF && host_addr_i[11:2] == CR_ENABLE)
      w_conflict_nxt = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_conflict_nxt = 1'b0;
          w_err_nxt      = (mode_i == 2'd3);
          if (mode_i != 2'd3) begin
            w_latch     = 1'b1;
            w_busy_nxt  = 1'b1;
            w_idx_nxt   = 4'd0;
            w_cnt_nxt   = 17'd0;
            w_state_nxt = S_DISABLE;
          end
        end
      end
      S_DISABLE: begin
        if (!w_stall) begin
          w_seq_en    = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!w_stall) begin
          w_seq_en   = 1'b1;
          w_seq_word = table_word(r_idx);
          w_seq_data = w_tbl_data;
          if (r_idx == LAST_IDX) begin
            w_cnt_nxt   = 17'd0;
            w_state_nxt = S_WAIT_LOCK;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock) begin
          w_cnt_nxt   = 17'd0;
          w_state_nxt = S_SETTLE;
        end else if (r_cnt == LOCK_LAST) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 17'd1;
        end
      end
      S_SETTLE: begin
        // Lock lost before settling finished: start over with a fresh timeout.
        if (!w_lock) begin
          w_cnt_nxt   = 17'd0;
          w_state_nxt = S_WAIT_LOCK;
        end else if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt   = 17'd0;
          w_state_nxt = S_ENABLE;
        end else begin
          w_cnt_nxt = r_cnt + 17'd1;
        end
      end
      S_ENABLE: begin
        if (!r_en_after || !w_stall) begin
          w_seq_en    = r_en_after;
          w_seq_data  = 32'd1;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_cnt       <= 17'd0;
      r_mode      <= 2'd0;
      r_depth     <= 2'd0;
      r_en_after  <= 1'b0;
      r_lock_sync <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_conflict  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lock_sync <= {r_lock_sync[0], clk_locked_i};
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_conflict  <= w_conflict_nxt;
      if (w_latch) begin
        r_mode     <= mode_i;
        r_depth    <= depth_i;
        r_en_after <= enable_after_i;
      end
    end
  end

endmodule

// File: tb/tb_video_mode_sequencer.sv
// tb/tb_video_mode_sequencer.sv - scoreboard bench for video_mode_sequencer
module tb_video_mode_sequencer;

  logic        mem_clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [1:0]  depth_i = 2'd0;
  logic        enable_after_i = 1'b0;
  logic        clk_locked_i = 1'b1;
  logic        busy_o, done_o, err_o, conflict_o;
  logic        host_en_i = 1'b0;
  logic [3:0]  host_we_i = 4'h0;
  logic [11:0] host_addr_i = 12'h0;
  logic [31:0] host_wrdata_i = 32'h0;
  logic [31:0] host_rddata_o;
  logic        ctl_en_o;
  logic [3:0]  ctl_we_o;
  logic [11:0] ctl_addr_o;
  logic [31:0] ctl_wrdata_o;
  logic [31:0] ctl_rddata_i = 32'h0;

  always #5 mem_clk = ~mem_clk;

  video_mode_sequencer #(.SETTLE_CYCLES(20), .LOCK_TIMEOUT(16)) dut (
    .mem_clk(mem_clk), .rst_ni(rst_ni), .req_i(req_i), .mode_i(mode_i), .depth_i(depth_i),
    .enable_after_i(enable_after_i), .clk_locked_i(clk_locked_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .conflict_o(conflict_o), .host_en_i(host_en_i), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_wrdata_i(host_wrdata_i), .host_rddata_o(host_rddata_o),
    .ctl_en_o(ctl_en_o), .ctl_we_o(ctl_we_o), .ctl_addr_o(ctl_addr_o), .ctl_wrdata_o(ctl_wrdata_o),
    .ctl_rddata_i(ctl_rddata_i)
  );

  // Register block model: synchronous read; words >= 0x20 hold a fixed pattern.
  logic [31:0] regs [0:1023];
  always @(posedge mem_clk) begin
    if (ctl_en_o) begin
      if (ctl_we_o == 4'hF) regs[ctl_addr_o[11:2]] <= ctl_wrdata_o;
      ctl_rddata_i <= (ctl_addr_o[11:2] >= 10'h020) ? (32'hA000_0000 | {22'd0, ctl_addr_o[11:2]})
                                                    : regs[ctl_addr_o[11:2]];
    end
  end

  typedef struct { logic [9:0] word; logic [31:0] data; } wr_t;
  wr_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int seq_wr_cnt = 0;
  bit busy_seen = 0;

  // Hand-computed timing table: pxlfreq, pol, htot, hend, hss, hes, vtot, vend, vss, ves.
  int unsigned tbl [3][10] = '{
    '{25, 3, 800, 640, 656, 752, 525, 480, 490, 492},
    '{40, 0, 1056, 800, 840, 968, 628, 600, 601, 605},
    '{65, 3, 1344, 1024, 1048, 1184, 806, 768, 771, 777}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input logic [9:0] w, input int unsigned d);
    wr_t e;
    e.word = w;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_expected(input int m, input int dep, input int bpl, input bit en);
    push(10'h003, 0);
    push(10'h002, dep);
    push(10'h004, tbl[m][1]);
    push(10'h005, tbl[m][0]);
    push(10'h006, tbl[m][3]);
    push(10'h007, tbl[m][7]);
    push(10'h008, bpl);
    for (int i = 0; i < 8; i++) push(10'h010 + 10'(i), tbl[m][2+i]);
    if (en) push(10'h003, 1);
  endtask

  // Monitor: sequencer writes against the scoreboard, host passthrough, read-data return, done width.
  bit          rd_pend = 0;
  logic [31:0] rd_exp = 32'h0;
  bit          prev_done = 0;
  always @(negedge mem_clk) begin
    if (rst_ni) begin
      if (busy_o) busy_seen = 1;
      if (rd_pend) chk("host_rddata", host_rddata_o, rd_exp);
      rd_pend = 0;
      if (host_en_i) begin
        chk("host_passthrough", {15'd0, ctl_en_o, ctl_we_o, ctl_addr_o}, {15'd0, 1'b1, host_we_i, host_addr_i});
        if (host_we_i == 4'h0) begin
          rd_pend = 1;
          rd_exp = 32'hA000_0000 | {22'd0, host_addr_i[11:2]};
        end
      end else if (ctl_en_o) begin
        seq_wr_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_seq_write", {20'd0, ctl_addr_o}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("seq_addr", {20'd0, ctl_addr_o}, {20'd0, e.word, 2'b00});
          chk("seq_data", ctl_wrdata_o, e.data);
          chk("seq_we", {28'd0, ctl_we_o}, 32'hF);
        end
      end
      if (prev_done) chk("done_pulse_width", {31'd0, done_o}, 0);
      prev_done = done_o;
    end else begin
      prev_done = 0;
      rd_pend = 0;
    end
  end

  task automatic start_req(input logic [1:0] m, input logic [1:0] d, input bit en);
    @(posedge mem_clk); #1;
    req_i = 1; mode_i = m; depth_i = d; enable_after_i = en;
    @(posedge mem_clk); #1;
    req_i = 0;
  endtask

  task automatic wait_done(input bit host_reads, input int budget);
    bit got;
    int k;
    got = 0;
    k = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge mem_clk); #1;
      if (done_o) begin
        got = 1;
        break;
      end
      if (host_reads) begin
        host_en_i = n[0];
        host_we_i = 4'h0;
        host_addr_i = {10'h020 + k[9:0], 2'b00};
        if (n[0]) k++;
      end
    end
    host_en_i = 0;
    chk("done_seen", {31'd0, got}, 1);
  endtask

  task automatic wait_sb_le(input int lim, input int budget);
    int n;
    n = 0;
    while (sb.size() > lim && n < budget) begin
      @(posedge mem_clk); #1;
      n++;
    end
    chk_range("scoreboard_drain_wait", n, 0, budget - 1);
  endtask

  task automatic run_simple(input logic [1:0] m, input logic [1:0] d, input int bpl, input bit en,
                            input bit host_reads);
    int w0;
    w0 = seq_wr_cnt;
    push_expected(m, d, bpl, en);
    start_req(m, d, en);
    wait_done(host_reads, 400);
    chk("scoreboard_empty", sb.size(), 0);
    chk("seq_write_count", seq_wr_cnt - w0, en ? 16 : 15);
    chk("busy_after_done", {31'd0, busy_o}, 0);
  endtask

  initial begin
    int n;
    int w0;
    // Reset state
    repeat (3) @(posedge mem_clk);
    #1;
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_done", {31'd0, done_o}, 0);
    chk("rst_err", {31'd0, err_o}, 0);
    chk("rst_conflict", {31'd0, conflict_o}, 0);
    chk("rst_ctl_en", {31'd0, ctl_en_o}, 0);
    rst_ni = 1;
    repeat (2) @(posedge mem_clk);

    // Mode 0 / depth 0 / enable: BPL 2560
    run_simple(2'd0, 2'd0, 2560, 1, 0);
    // Mode 2 / depth 3 with host reads every other cycle: BPL 512
    run_simple(2'd2, 2'd3, 512, 1, 1);
    // Mode 1 / depth 2 / no enable: BPL 800
    run_simple(2'd1, 2'd2, 800, 0, 0);

    // Invalid mode: error, no writes, never busy; next valid request clears it
    w0 = seq_wr_cnt;
    busy_seen = 0;
    start_req(2'd3, 2'd0, 1);
    repeat (10) @(posedge mem_clk);
    #1;
    chk("invalid_err", {31'd0, err_o}, 1);
    chk("invalid_no_writes", seq_wr_cnt - w0, 0);
    chk("invalid_never_busy", {31'd0, busy_seen}, 0);
    push_expected(0, 1, 1280, 1);
    start_req(2'd0, 2'd1, 1);
    chk("err_cleared_by_req", {31'd0, err_o}, 0);
    chk("busy_after_req", {31'd0, busy_o}, 1);
    wait_done(0, 400);
    chk("scoreboard_empty", sb.size(), 0);

    // Lock timeout: no enable write, err after 16 cycles in WAIT_LOCK
    clk_locked_i = 0;
    repeat (3) @(posedge mem_clk);
    w0 = seq_wr_cnt;
    push_expected(0, 0, 2560, 0);
    start_req(2'd0, 2'd0, 1);
    wait_sb_le(0, 100);
    n = 0;
    while (!err_o && n < 100) begin
      @(posedge mem_clk); #1;
      n++;
    end
    chk_range("lock_timeout_latency", n, 16, 16);
    chk("timeout_err", {31'd0, err_o}, 1);
    chk("timeout_busy", {31'd0, busy_o}, 0);
    repeat (5) @(posedge mem_clk);
    #1;
    chk("timeout_write_count", seq_wr_cnt - w0, 15);
    clk_locked_i = 1;
    repeat (3) @(posedge mem_clk);

    // Lock drop during SETTLE restarts the settle count
    push_expected(1, 0, 3200, 1);
    start_req(2'd1, 2'd0, 1);
    wait_sb_le(1, 100);
    repeat (4) @(posedge mem_clk);
    #1;
    clk_locked_i = 0;
    repeat (3) @(posedge mem_clk);
    #1;
    clk_locked_i = 1;
    n = 0;
    while (!done_o && n < 100) begin
      @(posedge mem_clk); #1;
      n++;
    end
    chk_range("settle_restart_latency", n, 20, 26);
    chk("scoreboard_empty", sb.size(), 0);

    // Host writes CR_ENABLE mid-WRITE: conflict, sequence still completes
    push_expected(0, 0, 2560, 1);
    start_req(2'd0, 2'd0, 1);
    wait_sb_le(10, 100);
    host_en_i = 1; host_we_i = 4'hF; host_addr_i = 12'h00C; host_wrdata_i = 32'd1;
    @(posedge mem_clk); #1;
    host_en_i = 0; host_we_i = 4'h0; host_wrdata_i = 32'h0;
    chk("conflict_set", {31'd0, conflict_o}, 1);
    wait_done(0, 400);
    chk("scoreboard_empty", sb.size(), 0);
    chk("conflict_sticky", {31'd0, conflict_o}, 1);

    // Reset mid-WRITE returns outputs to reset values asynchronously
    push_expected(2, 0, 4096, 1);
    start_req(2'd2, 2'd0, 1);
    chk("conflict_cleared_by_req", {31'd0, conflict_o}, 0);
    wait_sb_le(8, 100);
    #2;
    rst_ni = 0;
    #1;
    chk("async_rst_busy", {31'd0, busy_o}, 0);
    chk("async_rst_ctl_en", {31'd0, ctl_en_o}, 0);
    chk("async_rst_flags", {29'd0, done_o, err_o, conflict_o}, 0);
    sb.delete();
    repeat (2) @(posedge mem_clk);
    #1;
    rst_ni = 1;
    run_simple(2'd1, 2'd0, 3200, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
